// File: rtl/seg_monitor.sv
// Seven-segment bus checker: synchronises and debounces the segment lines, decodes each settled
// pattern to a hex digit and checks that digits follow the counter sequence, counting F->0 wraps.
module seg_monitor #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned ACTIVE_LOW    = 0,
    parameter int unsigned WRAP_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        seg_in,
    input  logic              en,
    input  logic              clr_err,
    output logic [3:0]        value,
    output logic              dp_out,
    output logic              valid,
    output logic              pattern_ok,
    output logic              bad_pat,
    output logic              seq_err,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam int unsigned CntW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CntW-1:0] StabMax = CntW'(STABLE_CYCLES - 1);
    localparam logic [7:0] PolMask = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    typedef enum logic [1:0] {StEmpty, StTrack, StSettling} state_e;

    state_e            state_q, state_d;
    logic [7:0]        s1_q, s1_d, s2_q, s2_d, cand_q, cand_d, acc_q, acc_d;
    logic [CntW-1:0]   stab_q, stab_d;
    logic [3:0]        value_q, value_d, ref_q, ref_d;
    logic              dp_q, dp_d, valid_q, valid_d, pat_ok_q, pat_ok_d;
    logic              bad_q, bad_d, seq_q, seq_d, ref_valid_q, ref_valid_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;

    logic       accept, dec_ok, legal;
    logic [3:0] dec_digit;

    always_comb begin
        dec_ok    = 1'b1;
        dec_digit = 4'h0;
        case (cand_q[6:0])
            7'h3F: dec_digit = 4'h0;
            7'h06: dec_digit = 4'h1;
            7'h5B: dec_digit = 4'h2;
            7'h4F: dec_digit = 4'h3;
            7'h66: dec_digit = 4'h4;
            7'h6D: dec_digit = 4'h5;
            7'h7D: dec_digit = 4'h6;
            7'h07: dec_digit = 4'h7;
            7'h7F: dec_digit = 4'h8;
            7'h6F: dec_digit = 4'h9;
            7'h77: dec_digit = 4'hA;
            7'h7C: dec_digit = 4'hB;
            7'h39: dec_digit = 4'hC;
            7'h5E: dec_digit = 4'hD;
            7'h79: dec_digit = 4'hE;
            7'h71: dec_digit = 4'hF;
            default: dec_ok = 1'b0;
        endcase
    end

    assign accept = en && (s2_q == cand_q) && (stab_q == StabMax) &&
                    ((state_q == StEmpty) || (cand_q != acc_q));
    // dp must be lit exactly on the F->0 step
    assign legal  = (dec_digit == ref_q + 4'd1) && (cand_q[7] == (ref_q == 4'hF));

    always_comb begin
        s1_d        = seg_in ^ PolMask;
        s2_d        = s1_q;
        cand_d      = cand_q;
        stab_d      = stab_q;
        acc_d       = acc_q;
        state_d     = state_q;
        value_d     = value_q;
        dp_d        = dp_q;
        valid_d     = 1'b0;
        pat_ok_d    = pat_ok_q;
        bad_d       = bad_q;
        seq_d       = seq_q;
        wrap_d      = wrap_q;
        ref_d       = ref_q;
        ref_valid_d = ref_valid_q;

        if (clr_err) begin
            bad_d       = 1'b0;
            seq_d       = 1'b0;
            wrap_d      = '0;
            ref_valid_d = 1'b0;
        end

        if (s2_q != cand_q) begin
            cand_d = s2_q;
            stab_d = '0;
        end else if (!en) begin
            stab_d = '0;
        end else if (stab_q != StabMax) begin
            stab_d = stab_q + 1'b1;
        end

        unique case (state_q)
            StEmpty:    if (accept) state_d = StTrack;
            StTrack:    if (s2_q != cand_q) state_d = StSettling;
            StSettling: if (accept || ((s2_q != cand_q) && (s2_q == acc_q))) state_d = StTrack;
            default:    state_d = StEmpty;
        endcase

        // Accept events are applied after the clear so that they win over clr_err
        if (accept) begin
            acc_d = cand_q;
            if (dec_ok) begin
                valid_d  = 1'b1;
                value_d  = dec_digit;
                dp_d     = cand_q[7];
                pat_ok_d = 1'b1;
                if (ref_valid_q) begin
                    if (!legal) begin
                        seq_d = 1'b1;
                    end else if ((ref_q == 4'hF) && (wrap_d != '1)) begin
                        wrap_d = wrap_d + 1'b1;
                    end
                end
                ref_d       = dec_digit;
                ref_valid_d = 1'b1;
            end else begin
                bad_d    = 1'b1;
                pat_ok_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            s1_q        <= '0;
            s2_q        <= '0;
            cand_q      <= '0;
            acc_q       <= '0;
            stab_q      <= '0;
            value_q     <= '0;
            dp_q        <= 1'b0;
            valid_q     <= 1'b0;
            pat_ok_q    <= 1'b0;
            bad_q       <= 1'b0;
            seq_q       <= 1'b0;
            wrap_q      <= '0;
            ref_q       <= '0;
            ref_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            cand_q      <= cand_d;
            acc_q       <= acc_d;
            stab_q      <= stab_d;
            value_q     <= value_d;
            dp_q        <= dp_d;
            valid_q     <= valid_d;
            pat_ok_q    <= pat_ok_d;
            bad_q       <= bad_d;
            seq_q       <= seq_d;
            wrap_q      <= wrap_d;
            ref_q       <= ref_d;
            ref_valid_q <= ref_valid_d;
        end
    end

    assign value      = value_q;
    assign dp_out     = dp_q;
    assign valid      = valid_q;
    assign pattern_ok = pat_ok_q;
    assign bad_pat    = bad_q;
    assign seq_err    = seq_q;
    assign wrap_cnt   = wrap_q;

endmodule

// File: tb/tb_seg_monitor.sv
// Directed bench for seg_monitor: an active-high bus instance carries most scenarios, a second
// active-low instance checks the input polarity fix.
module tb_seg_monitor;

    logic       clk = 1'b0;
    logic       rst, en, clr_err, en_al;
    logic [7:0] seg_in, seg_al;
    logic [3:0] value, value_al;
    logic       dp_out, valid, pattern_ok, bad_pat, seq_err;
    logic       dp_al, valid_al, pok_al, bad_al, seq_al;
    logic [7:0] wrap_cnt, wrap_al;

    int checks = 0;
    int failures = 0;
    int vcount;

    logic [7:0] pats [17] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F,
                              8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'hBF};

    seg_monitor #(.STABLE_CYCLES(4), .ACTIVE_LOW(0), .WRAP_W(8)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .en(en), .clr_err(clr_err),
        .value(value), .dp_out(dp_out), .valid(valid), .pattern_ok(pattern_ok),
        .bad_pat(bad_pat), .seq_err(seq_err), .wrap_cnt(wrap_cnt)
    );

    seg_monitor #(.STABLE_CYCLES(4), .ACTIVE_LOW(1), .WRAP_W(8)) dut_al (
        .clk(clk), .rst(rst), .seg_in(seg_al), .en(en_al), .clr_err(clr_err),
        .value(value_al), .dp_out(dp_al), .valid(valid_al), .pattern_ok(pok_al),
        .bad_pat(bad_al), .seq_err(seq_al), .wrap_cnt(wrap_al)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [7:0] pat, input int n);
        seg_in = pat;
        for (int i = 0; i < n; i++) begin
            tick();
            if (valid) vcount++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clr_err = 1'b0; seg_in = 8'h00;
        en_al = 1'b0; seg_al = 8'hFF;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (value !== 4'h0) begin failures++; $display("FAIL reset_value got=%0h want=0", value); end
        checks++; if (dp_out !== 1'b0) begin failures++; $display("FAIL reset_dp got=%b want=0", dp_out); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid); end
        checks++; if (pattern_ok !== 1'b0) begin failures++; $display("FAIL reset_pok got=%b want=0", pattern_ok); end
        checks++; if (bad_pat !== 1'b0) begin failures++; $display("FAIL reset_bad got=%b want=0", bad_pat); end
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL reset_seq got=%b want=0", seq_err); end
        checks++; if (wrap_cnt !== 8'd0) begin failures++; $display("FAIL reset_wrap got=%0d want=0", wrap_cnt); end
    endtask

    task automatic test_first_accept();
        int first_edge;
        first_edge = 0;
        vcount = 0;
        en = 1'b1;
        seg_in = 8'h3F;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (valid) begin
                vcount++;
                if (first_edge == 0) first_edge = e;
            end
        end
        checks++; if (vcount != 1) begin failures++; $display("FAIL first_pulses got=%0d want=1", vcount); end
        checks++; if (first_edge != 7) begin failures++; $display("FAIL first_edge got=%0d want=7", first_edge); end
        checks++; if (value !== 4'h0) begin failures++; $display("FAIL first_value got=%0h want=0", value); end
        checks++; if (dp_out !== 1'b0) begin failures++; $display("FAIL first_dp got=%b want=0", dp_out); end
        checks++; if (pattern_ok !== 1'b1) begin failures++; $display("FAIL first_pok got=%b want=1", pattern_ok); end
        checks++; if (bad_pat !== 1'b0 || seq_err !== 1'b0) begin
            failures++; $display("FAIL first_errs got=%b%b want=00", bad_pat, seq_err);
        end
    endtask

    task automatic test_count_sequence();
        do_reset();
        en = 1'b1;
        vcount = 0;
        for (int i = 0; i < 17; i++) hold(pats[i], 10);
        checks++; if (vcount != 17) begin failures++; $display("FAIL seq_pulses got=%0d want=17", vcount); end
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL seq_err got=%b want=0", seq_err); end
        checks++; if (wrap_cnt !== 8'd1) begin failures++; $display("FAIL seq_wrap got=%0d want=1", wrap_cnt); end
        checks++; if (dp_out !== 1'b1) begin failures++; $display("FAIL seq_dp got=%b want=1", dp_out); end
        checks++; if (value !== 4'h0) begin failures++; $display("FAIL seq_value got=%0h want=0", value); end
        checks++; if (bad_pat !== 1'b0) begin failures++; $display("FAIL seq_bad got=%b want=0", bad_pat); end
    endtask

    task automatic test_glitch();
        vcount = 0;
        hold(8'h06, 10);
        checks++; if (vcount != 1 || value !== 4'h1) begin
            failures++; $display("FAIL glitch_setup pulses=%0d value=%0h want 1/1", vcount, value);
        end
        vcount = 0;
        hold(8'h5B, 3);
        hold(8'h06, 10);
        checks++; if (vcount != 0) begin failures++; $display("FAIL glitch3_pulses got=%0d want=0", vcount); end
        checks++; if (value !== 4'h1 || seq_err !== 1'b0) begin
            failures++; $display("FAIL glitch3_state value=%0h seq=%b want 1/0", value, seq_err);
        end
        // Shortest glitch that survives: 5 sampled cycles with STABLE_CYCLES=4
        vcount = 0;
        hold(8'h5B, 5);
        hold(8'h06, 10);
        checks++; if (vcount != 2) begin failures++; $display("FAIL glitch5_pulses got=%0d want=2", vcount); end
        checks++; if (seq_err !== 1'b1 || value !== 4'h1) begin
            failures++; $display("FAIL glitch5_state seq=%b value=%0h want 1/1", seq_err, value);
        end
    endtask

    task automatic test_seq_skip();
        do_reset();
        en = 1'b1;
        hold(8'h3F, 10);
        hold(8'h4F, 10);
        checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL skip_seq got=%b want=1", seq_err); end
        checks++; if (value !== 4'h3) begin failures++; $display("FAIL skip_value got=%0h want=3", value); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL clr_seq got=%b want=0", seq_err); end
        hold(8'h66, 10);
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL exempt_seq got=%b want=0", seq_err); end
        checks++; if (value !== 4'h4) begin failures++; $display("FAIL exempt_value got=%0h want=4", value); end
    endtask

    task automatic test_bad_pattern();
        vcount = 0;
        hold(8'h00, 10);
        checks++; if (bad_pat !== 1'b1) begin failures++; $display("FAIL bad_flag got=%b want=1", bad_pat); end
        checks++; if (pattern_ok !== 1'b0) begin failures++; $display("FAIL bad_pok got=%b want=0", pattern_ok); end
        checks++; if (vcount != 0) begin failures++; $display("FAIL bad_pulses got=%0d want=0", vcount); end
        checks++; if (value !== 4'h4) begin failures++; $display("FAIL bad_value got=%0h want=4", value); end
        // Second undecodable pattern: its accept lands on edge 7, together with clr_err
        hold(8'h01, 6);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (bad_pat !== 1'b1) begin failures++; $display("FAIL bad_vs_clr got=%b want=1", bad_pat); end
    endtask

    task automatic test_reset_mid_settle();
        hold(8'h6D, 4);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (value !== 4'h0) begin failures++; $display("FAIL mid_value got=%0h want=0", value); end
        checks++; if (bad_pat !== 1'b0) begin failures++; $display("FAIL mid_bad got=%b want=0", bad_pat); end
        checks++; if (dp_out !== 1'b0 || valid !== 1'b0 || pattern_ok !== 1'b0) begin
            failures++; $display("FAIL mid_flags dp=%b valid=%b pok=%b want 000", dp_out, valid, pattern_ok);
        end
        checks++; if (seq_err !== 1'b0 || wrap_cnt !== 8'd0) begin
            failures++; $display("FAIL mid_errs seq=%b wrap=%0d want 0/0", seq_err, wrap_cnt);
        end
        en = 1'b0;
        seg_in = 8'h00;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (valid !== 1'b0 || value !== 4'h0) begin
            failures++; $display("FAIL mid_after valid=%b value=%0h want 0/0", valid, value);
        end
    endtask

    task automatic test_active_low();
        int pulses;
        pulses = 0;
        en_al = 1'b1;
        seg_al = 8'hF9;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid_al) pulses++;
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL al_pulses got=%0d want=1", pulses); end
        checks++; if (value_al !== 4'h1) begin failures++; $display("FAIL al_value got=%0h want=1", value_al); end
        checks++; if (dp_al !== 1'b0) begin failures++; $display("FAIL al_dp got=%b want=0", dp_al); end
        checks++; if (pok_al !== 1'b1 || bad_al !== 1'b0) begin
            failures++; $display("FAIL al_flags pok=%b bad=%b want 1/0", pok_al, bad_al);
        end
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_count_sequence();
        test_glitch();
        test_seq_skip();
        test_bad_pattern();
        test_reset_mid_settle();
        test_active_low();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
